exe_stage_mdu: RTL and testbench
================================

# exe_stage_mdu

Parametrised, iterative multiply/divide unit for the execute stage. It implements the RV64M operations alongside the single-cycle ALU: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus their word forms. Operands are accepted through a valid/ready handshake. Each result is held on an output valid/ready handshake until the pipeline takes it. A flush input kills in-flight work on a mispredict or exception.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width. Must be even and at least 32.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: unit can accept an operation. High only in IDLE.
- `op1` input XLEN: rs1 value.
- `op2` input XLEN: rs2 value.
- `mdu_info` input 8: one-hot op select. Bit order: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `is_word_opt` input 1: word form. Operates on the low 32 bits and sign-extends bit 31 of the result to XLEN.
- `flush` input 1: abort current operation.
- `out_valid` output 1: `mdu_output` is valid.
- `out_ready` input 1: consumer takes the result.
- `mdu_output` output XLEN: result.
- `busy` output 1: state is not IDLE.

## Operation
- State machine: IDLE, CALC, DONE.
  - IDLE → CALC on `in_valid & in_ready & ~flush`, except for the special cases below.
  - CALC → DONE when the iteration counter reaches N-1.
  - DONE → IDLE on `out_ready`.
- Iteration count N is XLEN for normal ops and 32 when `is_word_opt` is set.
- Capture:
  - Latch operands, op select and word flag.
  - For word ops, sign-extend bits 31:0 for signed ops and zero-extend them for unsigned ops before any processing.
  - Convert signed operands to magnitudes. Record the result sign:
    - product: sign(op1) XOR sign(op2). MULHSU treats op2 as unsigned.
    - quotient: sign XOR of the operands.
    - remainder: sign of the dividend.
- Multiply:
  - Radix-2 shift-add over N cycles into a 2N-bit accumulator.
  - Negate the accumulator if the result sign is negative.
  - MUL returns the low N bits. MULH, MULHSU and MULHU return the high N bits.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Negate quotient and remainder by their recorded signs in the DONE transition.
- Special cases (divider only), both go IDLE → DONE directly:
  - Divisor zero: quotient all-ones, remainder = dividend.
  - Signed overflow, dividend = −2^(N-1) with divisor −1: quotient = dividend, remainder 0.
- `mdu_output` is registered. It is loaded on entry to DONE and is stable while `out_valid` is high.
- Flush:
  - `flush` in any state returns to IDLE on the next edge and clears `out_valid`. No result is produced.
  - `flush` together with `in_valid` in IDLE: the operation is not accepted.
- An illegal `mdu_info` value (zero or multi-hot) is treated as MUL.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `mdu_output` 0, counter 0.
- Reset has priority over `flush` and over all handshakes.
- Accept edge is T.
  - Normal ops: CALC runs from T+1 to T+N; `out_valid` rises at T+N+1. This is 65 cycles for 64-bit ops and 33 cycles for word ops.
  - Special-case divides: `out_valid` rises at T+1.
- `out_valid` holds until the edge where `out_ready` is sampled high. `in_ready` returns high in the following cycle. There is no accept in the same cycle as result retirement.
- Back-to-back throughput: one op per N+2 cycles with `out_ready` held high.
- Reset or flush mid-CALC: the counter is cleared and no partial result is visible.

## Configuration
- `MDU_DIV_EN` defined: the divider and its special cases are built as above.
- `MDU_DIV_EN` undefined:
  - No divider hardware is built.
  - DIV, DIVU, REM and REMU go IDLE → DONE with `mdu_output` = 0, so `out_valid` rises at T+1.
  - Multiply ops are unchanged.

## Test plan
- MUL with XLEN=64, `op1`=0xFFFF_FFFF_FFFF_FFFF (−1), `op2`=3 → `mdu_output`=0xFFFF_FFFF_FFFF_FFFD. `out_valid` is first seen 65 cycles after accept.
- MULHU with `op1`=`op2`=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- DIVW with `op1`=0x8000_0000 and `op2`=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 at T+1. REMW with the same operands → 0.
- DIV with `op2`=0 and `op1`=7 → 0xFFFF_FFFF_FFFF_FFFF at T+1. REM with the same operands → 7.
- REM with `op1`=−7 and `op2`=2 → −1 (0xFFFF_FFFF_FFFF_FFFF). DIVU with `op1`=100 and `op2`=7 → 14.
- Flush asserted 10 cycles into a DIV → IDLE next edge, `out_valid` never rises, `in_ready`=1. Then a new MULW with `op1`=0x7FFF_FFFF and `op2`=2 is accepted → 0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: iterative RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle.
// Build option: define MDU_DIV_EN to include the divider. Without it, divide and remainder
// ops complete in one cycle with a zero result.
module exe_stage_mdu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [7:0]      mdu_info,
  input  logic            is_word_opt,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_output,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  typedef enum logic [2:0] {
    OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
  } op_e;

  state_e            state_q;
  op_e               op_q, in_op;
  logic [CntW-1:0]   cnt_q;
  logic              word_q, neg_q;
  logic [2*XLEN-1:0] prod_q, mcand_q, prod_nxt, prod_fin;
  logic [XLEN-1:0]   mplier_q, out_q;
  logic              in_s1, in_s2, in_neg1, in_neg2, in_div, last_iter;
  logic [XLEN-1:0]   ext1, ext2, mag1, mag2, mul_res, calc_res;

  // Word results are the low 32 bits sign-extended to XLEN.
  function automatic logic [XLEN-1:0] word_fix(input logic word, input logic [XLEN-1:0] v);
    return word ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Decode the op select (anything not exactly one-hot is MUL) and prepare operand magnitudes.
  always_comb begin
    case (mdu_info)
      8'b0000_0010: in_op = OpMulh;
      8'b0000_0100: in_op = OpMulhsu;
      8'b0000_1000: in_op = OpMulhu;
      8'b0001_0000: in_op = OpDiv;
      8'b0010_0000: in_op = OpDivu;
      8'b0100_0000: in_op = OpRem;
      8'b1000_0000: in_op = OpRemu;
      default:      in_op = OpMul;
    endcase
    in_s1   = in_op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    in_s2   = in_op inside {OpMulh, OpDiv, OpRem};
    in_div  = in_op inside {OpDiv, OpDivu, OpRem, OpRemu};
    ext1    = !is_word_opt ? op1 : (in_s1 ? XLEN'($signed(op1[31:0])) : XLEN'(op1[31:0]));
    ext2    = !is_word_opt ? op2 : (in_s2 ? XLEN'($signed(op2[31:0])) : XLEN'(op2[31:0]));
    in_neg1 = in_s1 & ext1[XLEN-1];
    in_neg2 = in_s2 & ext2[XLEN-1];
    mag1    = in_neg1 ? -ext1 : ext1;
    mag2    = in_neg2 ? -ext2 : ext2;
  end

  // One shift-add step and the signed, width-selected multiply result of the final step.
  always_comb begin
    prod_nxt = mplier_q[0] ? prod_q + mcand_q : prod_q;
    prod_fin = neg_q ? -prod_nxt : prod_nxt;
    if (op_q == OpMul) begin
      mul_res = word_q ? XLEN'(prod_fin[31:0]) : prod_fin[XLEN-1:0];
    end else begin
      mul_res = word_q ? XLEN'(prod_fin[63:32]) : prod_fin[2*XLEN-1:XLEN];
    end
    last_iter = word_q ? (cnt_q == CntW'(31)) : (cnt_q == CntW'(XLEN - 1));
  end

`ifdef MDU_DIV_EN
  logic            neg_rem_q, rem_ge, div_zero, div_ovf;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, rem_nxt, quo_nxt, div_res, spec_res, min_val;
  logic [XLEN:0]   rem_t;

  // Special-case detection at capture, plus one restoring-division step.
  always_comb begin
    min_val  = is_word_opt ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (ext2 == '0);
    div_ovf  = in_s1 && (ext1 == min_val) && (ext2 == '1);
    if (in_op inside {OpRem, OpRemu}) spec_res = div_zero ? ext1 : '0;
    else                              spec_res = div_zero ? '1 : ext1;
    // Dividend bits enter from the top of quo_q; word dividends are pre-aligned there.
    rem_t   = {rem_q, quo_q[XLEN-1]};
    rem_ge  = rem_t >= {1'b0, dvsr_q};
    rem_nxt = rem_ge ? XLEN'(rem_t - {1'b0, dvsr_q}) : rem_t[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], rem_ge};
    if (op_q inside {OpDiv, OpDivu}) div_res = neg_q ? -quo_nxt : quo_nxt;
    else                             div_res = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  assign calc_res = word_fix(word_q, (op_q inside {OpDiv, OpDivu, OpRem, OpRemu}) ?
                                     div_res : mul_res);
`else
  assign calc_res = word_fix(word_q, mul_res);
`endif

  // Control FSM and datapath registers; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= in_op;
            word_q   <= is_word_opt;
            neg_q    <= in_neg1 ^ in_neg2;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= (2*XLEN)'(mag2);
            mplier_q <= mag1;
`ifdef MDU_DIV_EN
            neg_rem_q <= in_neg1;
            rem_q     <= '0;
            quo_q     <= is_word_opt ? mag1 << (XLEN - 32) : mag1;
            dvsr_q    <= mag2;
            if (in_div && (div_zero || div_ovf)) begin
              state_q <= StDone;
              out_q   <= word_fix(is_word_opt, spec_res);
            end else begin
              state_q <= StCalc;
            end
`else
            if (in_div) begin
              state_q <= StDone;
              out_q   <= '0;
            end else begin
              state_q <= StCalc;
            end
`endif
          end
        end
        StCalc: begin
          cnt_q    <= cnt_q + CntW'(1);
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`ifdef MDU_DIV_EN
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
`endif
          if (last_iter) begin
            state_q <= StDone;
            cnt_q   <= '0;
            out_q   <= calc_res;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign mdu_output = out_q;

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Scoreboard bench for exe_stage_mdu: directed vectors push expected results, a monitor
// pops and compares value, latency and hold stability whenever out_valid is presented.
module tb_exe_stage_mdu;
  localparam int XLEN = 64;
`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_word_opt, flush, out_valid, out_ready, busy;
  logic [63:0] op1, op2, mdu_output, held;
  logic [7:0]  mdu_info;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          holding = 1'b0;

  typedef struct {
    logic [63:0] val;
    int          lat;
    int          acc;
    int          id;
  } exp_t;
  exp_t sb[$];

  exe_stage_mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1        (op1),
    .op2        (op2),
    .mdu_info   (mdu_info),
    .is_word_opt(is_word_opt),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mdu_output (mdu_output),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %h, want %h", name, id, act, exp);
    end
  endtask

  // Wait for in_ready, present one op for one edge; optionally push its expected result.
  task automatic issue(input int id, input logic [7:0] info, input bit word,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] val, input int lat, input bit track);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("accept", id, 64'(in_ready), 64'd1);
    if (!in_ready) return;
    in_valid    = 1'b1;
    mdu_info    = info;
    is_word_opt = word;
    op1         = a;
    op2         = b;
    if (track) begin
      e.val = val;
      e.lat = lat;
      e.acc = cyc + 1;
      e.id  = id;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consumer back-pressure: stall one cycle in three.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = (cyc % 3) != 0;
    end
  end

  // Monitor: compare on first sight of out_valid, then require a stable value until taken.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else if (out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          held    = mdu_output;
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected output: got %h, want no result", mdu_output);
          end else begin
            e = sb.pop_front();
            check("result", e.id, mdu_output, e.val);
            check("latency", e.id, 64'(cyc - e.acc + 1), 64'(e.lat));
          end
        end else begin
          check("stable", -1, mdu_output, held);
        end
        if (out_ready) holding = 1'b0;
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; is_word_opt = 1'b0;
    op1 = '0; op2 = '0; mdu_info = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 0, 64'(in_ready), 64'd1);
    check("rst_out_valid", 0, 64'(out_valid), 64'd0);
    check("rst_busy", 0, 64'(busy), 64'd0);
    check("rst_output", 0, mdu_output, 64'd0);
    rst = 1'b0;

    // Multiplies
    issue(1, 8'h01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1);
    issue(2, 8'h08, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    issue(3, 8'h02, 0, '1, '1, 64'h0, 65, 1);
    issue(4, 8'h04, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
    issue(5, 8'h00, 0, 64'd5, 64'd6, 64'd30, 65, 1);
    issue(6, 8'h03, 0, 64'd3, 64'd4, 64'd12, 65, 1);
    issue(7, 8'h01, 1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, 1);

    // Divides: special cases, then iterative ones
    issue(8, 8'h10, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          DivEn ? 64'hFFFF_FFFF_8000_0000 : 64'h0, 1, 1);
    issue(9, 8'h40, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 1, 1);
    issue(10, 8'h10, 0, 64'd7, 64'd0, DivEn ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, 1, 1);
    issue(11, 8'h40, 0, 64'd7, 64'd0, DivEn ? 64'd7 : 64'h0, 1, 1);
    issue(12, 8'h40, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          DivEn ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, DivEn ? 65 : 1, 1);
    issue(13, 8'h20, 0, 64'd100, 64'd7, DivEn ? 64'd14 : 64'h0, DivEn ? 65 : 1, 1);
    issue(14, 8'h10, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          DivEn ? 64'hFFFF_FFFF_FFFF_FFF2 : 64'h0, DivEn ? 65 : 1, 1);
    issue(15, 8'h20, 1, 64'h0000_0000_8000_0000, 64'd2,
          DivEn ? 64'h0000_0000_4000_0000 : 64'h0, DivEn ? 33 : 1, 1);
    issue(16, 8'h80, 1, 64'h1234_5678_FFFF_FFFF, 64'd16, DivEn ? 64'd15 : 64'h0,
          DivEn ? 33 : 1, 1);

    // Flush ten cycles into a long op: nothing may come out
    issue(20, DivEn ? 8'h10 : 8'h08, 0, 64'd100, 64'd7, 64'h0, 0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 20, 64'(busy), 64'd0);
    check("flush_in_ready", 20, 64'(in_ready), 64'd1);
    check("flush_out_valid", 20, 64'(out_valid), 64'd0);

    // in_valid together with flush in IDLE is not accepted
    in_valid = 1'b1; flush = 1'b1; mdu_info = 8'h01; is_word_opt = 1'b0;
    op1 = 64'd3; op2 = 64'd3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", 21, 64'(busy), 64'd0);
    check("flush_accept_in_ready", 21, 64'(in_ready), 64'd1);

    // Reset mid-calculation clears the unit and the held output
    issue(22, 8'h01, 0, 64'd5, 64'd5, 64'h0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 22, 64'(busy), 64'd0);
    check("midrst_out_valid", 22, 64'(out_valid), 64'd0);
    check("midrst_output", 22, mdu_output, 64'd0);
    rst = 1'b0;

    issue(23, 8'h01, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1);

    guard = 0;
    while ((sb.size() != 0 || holding) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", -1, 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
